// File: rtl/alu_pkg.sv
// Shared types for the ALU and the shared-ALU arbiter: ALU op encoding and
// the response-register occupancy state.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100,
      ALU_XOR = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_op_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } share_state_t;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU; Zero compares the operands regardless of the op.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] srca,
   input  logic [DATA_WIDTH-1:0] srcb,
   input  alu_op_t               ctrl,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero
);

   // Shifts take the full srcb; a shift amount of DATA_WIDTH or more yields 0.
   always_comb begin
      result = '0;
      case (ctrl)
         ALU_ADD: result = srca + srcb;
         ALU_SUB: result = srca - srcb;
         ALU_AND: result = srca & srcb;
         ALU_OR:  result = srca | srcb;
         ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, (srca < srcb)};
         ALU_XOR: result = srca ^ srcb;
         ALU_SLL: result = srca << srcb;
         ALU_SRL: result = srca >> srcb;
         default: result = '0;
      endcase
   end

   assign zero = (srca == srcb);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters, with a single
// registered response slot. Define ALU_SHARE_PERF_EN to add perf counters.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 3,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 req_valid,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_srca,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_srcb,
   input  logic [NUM_REQ-1:0][2:0]            req_ctrl,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [DATA_WIDTH-1:0]              resp_result,
   output logic                               resp_zero,
   output logic [ID_WIDTH-1:0]                resp_id
`ifdef ALU_SHARE_PERF_EN
   ,
   output logic [31:0]                        perf_grants,
   output logic [31:0]                        perf_stalls,
   output logic [31:0]                        perf_conflicts
`endif
);

   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

   share_state_t          state_q, state_d;
   logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [DATA_WIDTH-1:0] resp_result_q, resp_result_d;
   logic                  resp_zero_q, resp_zero_d;
   logic [ID_WIDTH-1:0]   resp_id_q, resp_id_d;

   logic [ID_WIDTH:0]     pick;
   logic                  found;
   logic [ID_WIDTH-1:0]   winner;
   logic                  can_accept;
   logic                  grant;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_zero;

   // Returns {found, index}; descending scan so the candidate closest to ptr wins.
   function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [ID_WIDTH-1:0] ptr);
      logic [ID_WIDTH:0]   sel_pick;
      logic [ID_WIDTH-1:0] sel;
      int                  idx;
      sel_pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = idx[ID_WIDTH-1:0];
         if (valid[sel]) sel_pick = {1'b1, sel};
      end
      return sel_pick;
   endfunction

   assign pick       = rr_pick(req_valid, rr_ptr_q);
   assign found      = pick[ID_WIDTH];
   assign winner     = pick[ID_WIDTH-1:0];
   assign can_accept = (state_q == EMPTY) || resp_ready;
   assign grant      = rst_n && found && can_accept;

   alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
      .srca   (req_srca[winner]),
      .srcb   (req_srcb[winner]),
      .ctrl   (alu_op_t'(req_ctrl[winner])),
      .result (alu_result),
      .zero   (alu_zero)
   );

   always_comb begin
      req_ready     = '0;
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      resp_result_d = resp_result_q;
      resp_zero_d   = resp_zero_q;
      resp_id_d     = resp_id_q;
      if (grant) begin
         req_ready[winner] = 1'b1;
         state_d           = FULL;
         rr_ptr_d          = (winner == LAST_ID) ? '0 : winner + 1'b1;
         resp_result_d     = alu_result;
         resp_zero_d       = alu_zero;
         resp_id_d         = winner;
      end else if (resp_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= EMPTY;
         rr_ptr_q      <= '0;
         resp_result_q <= '0;
         resp_zero_q   <= 1'b0;
         resp_id_q     <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         resp_result_q <= resp_result_d;
         resp_zero_q   <= resp_zero_d;
         resp_id_q     <= resp_id_d;
      end
   end

   assign resp_valid  = (state_q == FULL);
   assign resp_result = resp_result_q;
   assign resp_zero   = resp_zero_q;
   assign resp_id     = resp_id_q;

`ifdef ALU_SHARE_PERF_EN
   logic [31:0] perf_grants_q, perf_grants_d;
   logic [31:0] perf_stalls_q, perf_stalls_d;
   logic [31:0] perf_conflicts_q, perf_conflicts_d;

   // Saturating event counters; a conflict is any cycle with two or more valids.
   always_comb begin
      perf_grants_d    = perf_grants_q;
      perf_stalls_d    = perf_stalls_q;
      perf_conflicts_d = perf_conflicts_q;
      if (grant && (perf_grants_q != '1))
         perf_grants_d = perf_grants_q + 32'd1;
      if ((state_q == FULL) && !resp_ready && (|req_valid) && (perf_stalls_q != '1))
         perf_stalls_d = perf_stalls_q + 32'd1;
      if (((req_valid & (req_valid - 1'b1)) != '0) && (perf_conflicts_q != '1))
         perf_conflicts_d = perf_conflicts_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_grants_q    <= '0;
         perf_stalls_q    <= '0;
         perf_conflicts_q <= '0;
      end else begin
         perf_grants_q    <= perf_grants_d;
         perf_stalls_q    <= perf_stalls_d;
         perf_conflicts_q <= perf_conflicts_d;
      end
   end

   assign perf_grants    = perf_grants_q;
   assign perf_stalls    = perf_stalls_q;
   assign perf_conflicts = perf_conflicts_q;
`endif

   // A requester that has raised valid must hold it until accepted.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_no_retract
      a_no_retract: assert property (@(posedge clk) disable iff (!rst_n)
         (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
   end

endmodule
